// File: rtl/updown_sched_pkg.sv
// ---------------------------------------------------------------------------
// updown_sched_pkg
//
// Shared definitions for the up/down counter scheduler:
//   - sched_state_e : scheduler FSM states (idle, settle, run, done)
//   - MODE_UP / MODE_DOWN : counter direction encoding
//   - step_would_wrap() : tells whether one more step in a given direction
//     would wrap the counter around its range
// ---------------------------------------------------------------------------
package updown_sched_pkg;

    // The state literals carry an ST_ prefix so they never collide with the
    // SETTLE parameter of the scheduler that imports this package.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } sched_state_e;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // Counting up wraps from the all-ones value; counting down wraps from zero.
    function automatic logic step_would_wrap(input logic dir,
                                             input logic at_max,
                                             input logic at_zero);
        return (dir == MODE_UP) ? at_max : at_zero;
    endfunction

endpackage

// File: rtl/updown_count_scheduler_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
//
// Two-way round-robin pick between the up-client and the down-client. Purely
// combinational; the priority pointer is owned and updated by the scheduler.
//
// Ports:
//   up_req    in  1  up-client request
//   dn_req    in  1  down-client request
//   ptr       in  1  side that wins a tie (MODE_UP or MODE_DOWN)
//   gnt_valid out 1  at least one client is requesting
//   gnt_dn    out 1  winner is the down-client (only meaningful with gnt_valid)
// ---------------------------------------------------------------------------
module rr_arbiter_2
    import updown_sched_pkg::*;
(
    input  logic up_req,
    input  logic dn_req,
    input  logic ptr,
    output logic gnt_valid,
    output logic gnt_dn
);

    // A lone requester always wins; on a tie the pointer decides.
    always_comb begin
        gnt_valid = up_req | dn_req;
        gnt_dn    = dn_req & (~up_req | (ptr == MODE_DOWN));
    end

endmodule

// File: rtl/updown_count_scheduler.sv
// ---------------------------------------------------------------------------
// updown_count_scheduler
//
// Shares one T-flip-flop up/down counter between an up-client and a
// down-client. Requests are arbitrated round-robin; the counter direction is
// only changed while idle, followed by a settle interval with no toggles, and
// each grant then issues a fixed burst of toggle-enable pulses. A shadow copy
// of the count is kept for status.
//
// Parameters:
//   WIDTH   counter width in bits
//   SETTLE  idle cycles after a mode change (1..15)
//   BURST   count steps per grant (1..15)
//
// Ports:
//   clk     in  1      system clock, rising edge
//   rst     in  1      asynchronous active-high reset
//   up_req  in  1      level request from the up-client
//   dn_req  in  1      level request from the down-client
//   up_gnt  out 1      up-client owns the counter
//   dn_gnt  out 1      down-client owns the counter
//   mode    out 1      counter direction (0 up, 1 down)
//   t       out 1      toggle enable, one step per high cycle
//   count   out WIDTH  shadow count
//   busy    out 1      scheduler not idle
//   done    out 1      one-cycle pulse at the end of a grant
//   sat     out 1      one-cycle pulse when a burst stops early on a limit
//
// Build option:
//   SATURATE_EN  when defined, a step that would wrap is suppressed and the
//                burst ends early with sat pulsing alongside done; otherwise
//                the count wraps and sat stays 0.
// ---------------------------------------------------------------------------
module updown_count_scheduler
    import updown_sched_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2,
    parameter int BURST  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_req,
    input  logic             dn_req,
    output logic             up_gnt,
    output logic             dn_gnt,
    output logic             mode,
    output logic             t,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             sat
);

`ifdef SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE);
    localparam logic [3:0]       BURST_LAST  = 4'(BURST - 1);

    sched_state_e     state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [3:0]       remaining_q, remaining_d;
    logic             ptr_q, ptr_d;
    logic             up_gnt_q, up_gnt_d;
    logic             dn_gnt_q, dn_gnt_d;
    logic             mode_q, mode_d;
    logic             t_q, t_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sat_q, sat_d;

    logic             arb_valid;
    logic             arb_dn;
    logic [WIDTH-1:0] count_step;
    logic             entry_wrap;
    logic             wrap_next;
    logic             run_end;

    rr_arbiter_2 u_arb (
        .up_req    (up_req),
        .dn_req    (dn_req),
        .ptr       (ptr_q),
        .gnt_valid (arb_valid),
        .gnt_dn    (arb_dn)
    );

    // The shadow count follows the counter: t being high this cycle means
    // the counter takes one step in the current direction at the next edge.
    // entry_wrap looks at the count as it stands when a burst is about to
    // start; wrap_next looks one step ahead while a burst is running.
    always_comb begin
        count_step = count_q;
        if (t_q) begin
            count_step = (mode_q == MODE_DOWN) ? (count_q - ONE) : (count_q + ONE);
        end
        entry_wrap = SAT_EN & step_would_wrap(mode_q, &count_q, ~|count_q);
        wrap_next  = SAT_EN & step_would_wrap(mode_q, &count_step, ~|count_step);
        // A RUN cycle with t low only happens when the first step was
        // suppressed, so it ends the burst as well.
        run_end    = ~t_q | (remaining_q == 4'd0) | wrap_next;
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            settle_q    <= 4'd0;
            remaining_q <= 4'd0;
            ptr_q       <= MODE_UP;
            up_gnt_q    <= 1'b0;
            dn_gnt_q    <= 1'b0;
            mode_q      <= MODE_UP;
            t_q         <= 1'b0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            remaining_q <= remaining_d;
            ptr_q       <= ptr_d;
            up_gnt_q    <= up_gnt_d;
            dn_gnt_q    <= dn_gnt_d;
            mode_q      <= mode_d;
            t_q         <= t_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sat_q       <= sat_d;
        end
    end

    // Next-state logic. A grant in the current direction goes straight to
    // RUN; a direction change detours through SETTLE first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = (arb_dn == mode_q) ? ST_RUN : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == 4'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values. t is registered, so it is decided one
    // cycle ahead: it goes high for the cycle after the grant (or after the
    // settle interval) and stays high until the last step has been issued.
    always_comb begin
        settle_d    = settle_q;
        remaining_d = remaining_q;
        ptr_d       = ptr_q;
        up_gnt_d    = up_gnt_q;
        dn_gnt_d    = dn_gnt_q;
        mode_d      = mode_q;
        t_d         = 1'b0;
        count_d     = count_step;
        busy_d      = (state_d != ST_IDLE);
        done_d      = 1'b0;
        sat_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    up_gnt_d = ~arb_dn;
                    dn_gnt_d = arb_dn;
                    if (arb_dn == mode_q) begin
                        t_d         = ~entry_wrap;
                        remaining_d = BURST_LAST;
                    end else begin
                        mode_d   = arb_dn;
                        settle_d = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q - 4'd1;
                if (settle_q == 4'd1) begin
                    t_d         = ~entry_wrap;
                    remaining_d = BURST_LAST;
                end
            end
            ST_RUN: begin
                if (run_end) begin
                    up_gnt_d = 1'b0;
                    dn_gnt_d = 1'b0;
                    done_d   = 1'b1;
                    // Only an early stop counts as saturation; a burst whose
                    // last step lands on the limit finished normally.
                    sat_d    = SAT_EN & (~t_q | ((remaining_q != 4'd0) & wrap_next));
                end else begin
                    t_d         = 1'b1;
                    remaining_d = remaining_q - 4'd1;
                end
            end
            ST_DONE: begin
                // mode still reflects the side just served, so the pointer
                // hands tie priority to the other side.
                ptr_d = ~mode_q;
            end
            default: begin
                t_d = 1'b0;
            end
        endcase
    end

    assign up_gnt = up_gnt_q;
    assign dn_gnt = dn_gnt_q;
    assign mode   = mode_q;
    assign t      = t_q;
    assign count  = count_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign sat    = sat_q;

endmodule

// File: tb/tb_updown_count_scheduler.sv
// ---------------------------------------------------------------------------
// tb_updown_count_scheduler
//
// Directed bench for updown_count_scheduler with default parameters
// (WIDTH=4, SETTLE=2, BURST=4). Expected values are hand-derived from the
// scheduler timing: same-direction grants run t for BURST cycles from the
// sampling edge, direction changes add SETTLE cycles in front.
// ---------------------------------------------------------------------------
module tb_updown_count_scheduler;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 2;
    localparam int BURST  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             up_req;
    logic             dn_req;
    logic             up_gnt;
    logic             dn_gnt;
    logic             mode;
    logic             t;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             sat;

    int checks   = 0;
    int failures = 0;

    updown_count_scheduler #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE),
        .BURST  (BURST)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .up_req (up_req),
        .dn_req (dn_req),
        .up_gnt (up_gnt),
        .dn_gnt (dn_gnt),
        .mode   (mode),
        .t      (t),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .sat    (sat)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive both request lines at once.
    task automatic applyStimulus(input logic up, input logic dn);
        up_req = up;
        dn_req = dn;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the done pulse.
    task automatic waitDone(input string tag);
        for (int i = 0; i < 50 && done !== 1'b1; i++) begin
            tick();
        end
        checkOutput(tag, done, 1);
    endtask

    // One full grant from IDLE, request dropped after it has been sampled;
    // returns with the scheduler back in IDLE.
    task automatic runGrant(input logic up, input logic dn, input string tag);
        applyStimulus(up, dn);
        tick();
        applyStimulus(1'b0, 1'b0);
        waitDone(tag);
        tick();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_up_gnt"}, up_gnt, 0);
        checkOutput({tag, "_dn_gnt"}, dn_gnt, 0);
        checkOutput({tag, "_mode"},   mode,   0);
        checkOutput({tag, "_t"},      t,      0);
        checkOutput({tag, "_count"},  count,  0);
        checkOutput({tag, "_busy"},   busy,   0);
        checkOutput({tag, "_done"},   done,   0);
        checkOutput({tag, "_sat"},    sat,    0);
    endtask

    // Hard stop in case something leaves the stimulus stuck.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got 0 expected 1 (simulation time limit)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int order;
        int overlap;
        int settleCyc;
        int runCyc;
        int modeGlitch;
        int doneSeen;
        logic prevUp;
        logic prevDn;
        logic prevMode;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        checkResetValues("reset");
        rst = 1'b0;
        tick();

        // Up grant, same direction: t from E0 for BURST cycles, no settle.
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        for (int k = 0; k <= BURST; k++) begin
            checkOutput($sformatf("up_t%0d", k),    t,      (k < BURST));
            checkOutput($sformatf("up_gnt%0d", k),  up_gnt, (k < BURST));
            checkOutput($sformatf("up_cnt%0d", k),  count,  k);
            checkOutput($sformatf("up_done%0d", k), done,   (k == BURST));
            checkOutput($sformatf("up_mode%0d", k), mode,   0);
            if (k < BURST) tick();
        end
        tick();
        checkOutput("up_idle_busy", busy, 0);

        // Down grant alone: mode flips at E0, SETTLE quiet cycles, then steps.
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        for (int k = 0; k <= SETTLE + BURST; k++) begin
            checkOutput($sformatf("dn_t%0d", k),
                        t, (k >= SETTLE && k < SETTLE + BURST));
            checkOutput($sformatf("dn_gnt%0d", k), dn_gnt, (k < SETTLE + BURST));
            checkOutput($sformatf("dn_upgnt%0d", k), up_gnt, 0);
            checkOutput($sformatf("dn_cnt%0d", k),
                        count, (k <= SETTLE) ? 4 : 4 - (k - SETTLE));
            checkOutput($sformatf("dn_done%0d", k), done, (k == SETTLE + BURST));
            checkOutput($sformatf("dn_mode%0d", k), mode, 1);
            if (k < SETTLE + BURST) tick();
        end
        tick();

        // Both requests held: round-robin up, down, up, each with a settle.
        order      = 0;
        overlap    = 0;
        settleCyc  = 0;
        runCyc     = 0;
        modeGlitch = 0;
        doneSeen   = 0;
        prevUp     = up_gnt;
        prevDn     = dn_gnt;
        prevMode   = mode;
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 80 && doneSeen < 3; i++) begin
            tick();
            if (up_gnt && dn_gnt) overlap++;
            if (up_gnt && !prevUp) order = order * 10 + 1;
            if (dn_gnt && !prevDn) order = order * 10 + 2;
            if ((up_gnt || dn_gnt) && !t) settleCyc++;
            if (t) runCyc++;
            if (t && (mode != prevMode)) modeGlitch++;
            if (done) doneSeen++;
            prevUp   = up_gnt;
            prevDn   = dn_gnt;
            prevMode = mode;
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("rr_done_count", doneSeen,   3);
        checkOutput("rr_order",      order,      121);
        checkOutput("rr_overlap",    overlap,    0);
        checkOutput("rr_settle",     settleCyc,  3 * SETTLE);
        checkOutput("rr_run",        runCyc,     3 * BURST);
        checkOutput("rr_mode_glitch", modeGlitch, 0);
        checkOutput("rr_count",      count,      4);
        tick();
        tick();
        checkOutput("rr_idle_busy", busy, 0);

        // Two more up bursts bring the count to 12, then a burst at the top.
        runGrant(1'b1, 1'b0, "pre1_done");
        runGrant(1'b1, 1'b0, "pre2_done");
        checkOutput("pre_count", count, 12);
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
`ifdef SATURATE_EN
        for (int k = 0; k <= 3; k++) begin
            checkOutput($sformatf("sat_cnt%0d", k),  count, 12 + k);
            checkOutput($sformatf("sat_t%0d", k),    t,     (k < 3));
            checkOutput($sformatf("sat_done%0d", k), done,  (k == 3));
            checkOutput($sformatf("sat_sat%0d", k),  sat,   (k == 3));
            if (k < 3) tick();
        end
        tick();
        // Starting a burst already at the limit: no step, immediate end.
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("lim_gnt", up_gnt, 1);
        checkOutput("lim_t",   t,      0);
        tick();
        checkOutput("lim_done", done,  1);
        checkOutput("lim_sat",  sat,   1);
        checkOutput("lim_cnt",  count, 15);
        tick();
`else
        for (int k = 0; k <= BURST; k++) begin
            checkOutput($sformatf("wrap_cnt%0d", k),  count, (12 + k) % 16);
            checkOutput($sformatf("wrap_t%0d", k),    t,     (k < BURST));
            checkOutput($sformatf("wrap_done%0d", k), done,  (k == BURST));
            checkOutput($sformatf("wrap_sat%0d", k),  sat,   0);
            if (k < BURST) tick();
        end
        tick();
`endif

        // Clean start, then reset in the third RUN cycle.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        checkOutput("clean_count", count, 0);
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        checkOutput("mid_count", count, 2);
        checkOutput("mid_t", t, 1);
        rst = 1'b1;
        #1;
        checkResetValues("midrst");
        #2;
        rst = 1'b0;
        tick();
        checkOutput("postrst_busy", busy, 0);

        // Mode was reset to up, so a down grant must settle first.
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("postrst_dn_gnt", dn_gnt, 1);
        checkOutput("postrst_mode",   mode,   1);
        checkOutput("postrst_t0",     t,      0);
        tick();
        checkOutput("postrst_t1",     t,      0);
        checkOutput("postrst_gnt1",   dn_gnt, 1);
        tick();
        checkOutput("postrst_cnt2",   count,  0);
        waitDone("postrst_done");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_count_scheduler.md
# updown_count_scheduler

Controller that shares one up/down counter (T-flip-flop based, mode 0 = up, 1 = down) between two requesters: an up-client and a down-client. It arbitrates the requests round-robin and changes the counter mode only while the counter is idle. After every mode change it holds a settle interval, so no spurious count edges occur. It then issues a fixed burst of toggle-enable pulses. It keeps a shadow copy of the count for status and for the bench's reference model.

## Interface
- WIDTH, 4: counter width in bits.
- SETTLE, 2: idle cycles inserted after a mode change; legal range 1..15.
- BURST, 4: count steps per grant; legal range 1..15.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- up_req  in  1  level request from the up-client.
- dn_req  in  1  level request from the down-client.
- up_gnt  out  1  up-client owns the counter.
- dn_gnt  out  1  down-client owns the counter.
- mode  out  1  counter direction (0 up, 1 down); drives the counter's mode input.
- t  out  1  toggle enable to the counter; one step per cycle high.
- count  out  WIDTH  shadow count.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a grant.
- sat  out  1  one-cycle pulse when a burst ends early on a limit (see Configuration).

## Operation
- All outputs are registered.
- Reset values: up_gnt=0, dn_gnt=0, mode=0, t=0, count=0, busy=0, done=0, sat=0. The state goes to IDLE and the priority pointer selects up.
- FSM states: IDLE, SETTLE, RUN, DONE.
- IDLE
  - With no request, the block stays in IDLE.
  - With one request, that client wins.
  - With both requests, the pointer side wins.
  - Winner's gnt goes to 1.
  - If the winner's direction equals mode: go to RUN.
  - Otherwise: update mode, load the settle counter with SETTLE, go to SETTLE.
- SETTLE: t=0. Decrement the settle counter; go to RUN on the edge where it reaches 0. That gives exactly SETTLE cycles in SETTLE.
- RUN: t=1 for BURST cycles. Each cycle, count changes by +1 (up) or −1 (down), modulo 2^WIDTH. After the BURST-th step, go to DONE.
- DONE: gnt=0, t=0, done=1 for one cycle. The pointer flips to the opposite of the side just served. Return to IDLE.
- A request dropped mid-grant does not shorten the burst; the grant always completes.
- gnt is held through SETTLE and RUN and is never asserted to both clients.
- Minimum gap between grants: one DONE cycle plus one IDLE cycle.
- Reset asserted mid-burst forces the reset values immediately; steps already taken are discarded.

## Timing
- Let E0 be the first edge at which IDLE samples the winning request.
- Same direction:
  - gnt and t are high from E0 to E0+BURST.
  - count is final after E0+BURST.
  - done is high from E0+BURST to E0+BURST+1.
- Direction change:
  - mode changes at E0; t stays 0 until E0+SETTLE.
  - All RUN timings above shift by SETTLE.
- mode never changes while t=1.

## Configuration
- SATURATE_EN defined:
  - In RUN, a step that would wrap (up at 2^WIDTH−1, down at 0) is suppressed: t=0 that cycle and count holds.
  - The FSM goes straight to DONE; sat pulses together with done.
- SATURATE_EN undefined:
  - Count wraps modulo 2^WIDTH; sat is tied to 0.

## Structure
- Shared package updown_sched_pkg holds:
  - the state enum (IDLE, SETTLE, RUN, DONE);
  - MODE_UP=1'b0 and MODE_DOWN=1'b1.
- One sub-module, rr_arbiter_2: a two-way round-robin pick with the pointer as input. The pointer update stays in the FSM, taken on DONE.

## Test plan
- Reset, then up_req held high, defaults: no settle. t is high for 4 cycles, count reaches 4, done pulses at E0+4, mode stays 0.
- Then dn_req alone: mode goes to 1 at E0, t stays low for 2 cycles, then 4 down steps; count returns to 0 and done pulses at E0+6.
- Both requests held continuously: grants alternate up, down, up. Each down grant is preceded by SETTLE=2 and each up grant likewise. gnt is never high for both clients.
- Without SATURATE_EN, count=14 and an up burst of 4: count goes 15, 0, 1, 2 (wraps) and sat stays 0.
- With SATURATE_EN, same case: one step to 15, then done and sat pulse together, count stays 15, and the burst lasts 1 step.
- rst pulsed during the third RUN cycle: all outputs return to reset values at once. A subsequent dn_req is granted and a settle interval is inserted, because mode was reset to 0.
